// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the fetch stage.
// FETCH_HALT_ON_ZERO_EN adds the HALTED state.
package fetch_pkg;

  localparam int unsigned FETCH_WIDTH        = 16;
  localparam int unsigned FETCH_RESET_VECTOR = 0;
  localparam logic [15:0] HALT_WORD          = 16'h0000;

`ifdef FETCH_HALT_ON_ZERO_EN
  typedef enum logic [0:0] {
    ST_FETCH  = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_e;
`else
  typedef enum logic [0:0] {
    ST_FETCH  = 1'b0
  } fetch_state_e;
`endif

endpackage

// File: rtl/pc_register.sv
// Program counter: synchronous load, increment with natural wrap, or hold.
module pc_register
  import fetch_pkg::*;
#(
  parameter int unsigned WIDTH        = FETCH_WIDTH,
  parameter int unsigned RESET_VECTOR = FETCH_RESET_VECTOR
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             inc,
  output logic [WIDTH-1:0] pc
);

  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_value;
    end else if (inc) begin
      pc_d = pc_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= WIDTH'(RESET_VECTOR);
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_controller.sv
// Fetch stage: single-entry output slot fed from instruction memory at PC.
// FETCH_HALT_ON_ZERO_EN: a zero word halts fetch instead of being delivered.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int unsigned l            = FETCH_WIDTH,
  parameter int unsigned RESET_VECTOR = FETCH_RESET_VECTOR
) (
  input  logic         Clock,
  input  logic         Reset_n,
  output logic [l-1:0] Address,
  input  logic [l-1:0] Instruction,
  output logic [l-1:0] InstrOut,
  output logic [l-1:0] InstrPc,
  output logic         InstrValid,
  input  logic         InstrReady,
  input  logic         Redirect,
  input  logic [l-1:0] RedirectTarget,
  output logic         Halted,
  output logic [l-1:0] FetchCount
);

  fetch_state_e state_d, state_q;
  logic [l-1:0] instr_d, instr_q;
  logic [l-1:0] ipc_d, ipc_q;
  logic         valid_d, valid_q;
  logic [l-1:0] count_d, count_q;
  logic         transfer;
  logic         capture_en;
  logic         pc_load;
  logic         pc_inc;
  logic [l-1:0] pc;

  pc_register #(
    .WIDTH        (l),
    .RESET_VECTOR (RESET_VECTOR)
  ) u_pc (
    .clk        (Clock),
    .rst_n      (Reset_n),
    .load       (pc_load),
    .load_value (RedirectTarget),
    .inc        (pc_inc),
    .pc         (pc)
  );

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    ipc_d      = ipc_q;
    valid_d    = valid_q;
    count_d    = count_q;
    capture_en = 1'b0;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;
    transfer   = valid_q & InstrReady;

    // Transfer is counted even when a redirect flushes the slot this cycle.
    if (transfer) begin
      valid_d = 1'b0;
      if (count_q != '1) begin
        count_d = count_q + l'(1);
      end
    end

    if (Redirect) begin
      pc_load = 1'b1;
      valid_d = 1'b0;
      state_d = ST_FETCH;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (!valid_d) begin
`ifdef FETCH_HALT_ON_ZERO_EN
            if (Instruction == l'(HALT_WORD)) begin
              state_d = ST_HALTED;
            end else begin
              capture_en = 1'b1;
            end
`else
            capture_en = 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end

    if (capture_en) begin
      instr_d = Instruction;
      ipc_d   = pc;
      valid_d = 1'b1;
      pc_inc  = 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q <= ST_FETCH;
      instr_q <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign Address    = pc;
  assign InstrOut   = instr_q;
  assign InstrPc    = ipc_q;
  assign InstrValid = valid_q;
  assign FetchCount = count_q;
`ifdef FETCH_HALT_ON_ZERO_EN
  assign Halted     = (state_q == ST_HALTED);
`else
  assign Halted     = 1'b0;
`endif

endmodule
